// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner: pad sync, per-bit debounce, edge pulses and irq pending; GPIO_COND_INVERT_EN adds pad_inv polarity input
module gpio_in_conditioner #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     pad_in,
`ifdef GPIO_COND_INVERT_EN
    input  logic [WIDTH-1:0]     pad_inv,
`endif
    input  logic [DEB_CNT_W-1:0] deb_limit,
    input  logic [WIDTH-1:0]     rise_en,
    input  logic [WIDTH-1:0]     fall_en,
    input  logic [WIDTH-1:0]     irq_clr,
    output logic [WIDTH-1:0]     gpio_db,
    output logic [WIDTH-1:0]     rise_pulse,
    output logic [WIDTH-1:0]     fall_pulse,
    output logic [WIDTH-1:0]     irq_pending,
    output logic                 irq
);
    logic [WIDTH-1:0]     pad_c;
    logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]     s;
    logic [WIDTH-1:0]     db_d;
    logic [DEB_CNT_W-1:0] cnt [WIDTH];
`ifdef GPIO_COND_INVERT_EN
    assign pad_c = pad_in ^ pad_inv;
`else
    assign pad_c = pad_in;
`endif
    assign s   = sync_q[SYNC_STAGES-1];
    assign irq = |irq_pending;
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
            gpio_db     <= '0;
            db_d        <= '0;
            rise_pulse  <= '0;
            fall_pulse  <= '0;
            irq_pending <= '0;
        end else begin
            sync_q[0] <= pad_c;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            // >= lets a lowered limit take effect mid-count; cnt stops at limit so never wraps
            for (int i = 0; i < WIDTH; i++) begin
                if (s[i] != gpio_db[i]) begin
                    if (cnt[i] >= deb_limit) begin
                        gpio_db[i] <= s[i];
                        cnt[i]     <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
            db_d        <= gpio_db;
            rise_pulse  <= gpio_db & ~db_d;
            fall_pulse  <= ~gpio_db & db_d;
            irq_pending <= (irq_pending & ~irq_clr) | (rise_pulse & rise_en) | (fall_pulse & fall_en);
        end
    end
endmodule

// File: tb/tb_gpio_in_conditioner.sv
// tb_gpio_in_conditioner: directed checks of reset, debounce latency, glitch/bounce rejection, pending and threshold change
module tb_gpio_in_conditioner;
    logic        clk = 0;
    logic        rst;
    logic [31:0] pad_in, pad_inv, rise_en, fall_en, irq_clr;
    logic [15:0] deb_limit;
    logic [31:0] gpio_db, rise_pulse, fall_pulse, irq_pending;
    logic        irq;
    int          errors = 0;
    int          checks = 0;
    int          cnt_seen;

    always #5 clk = ~clk;

    gpio_in_conditioner dut (
        .clk(clk),
        .rst(rst),
        .pad_in(pad_in),
`ifdef GPIO_COND_INVERT_EN
        .pad_inv(pad_inv),
`endif
        .deb_limit(deb_limit),
        .rise_en(rise_en),
        .fall_en(fall_en),
        .irq_clr(irq_clr),
        .gpio_db(gpio_db),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .irq_pending(irq_pending),
        .irq(irq)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1; pad_in = 32'hFFFF_FFFF; pad_inv = 0; deb_limit = 0;
        rise_en = 0; fall_en = 0; irq_clr = 0;
        tick(3);
        chk("rst_gpio_db", gpio_db, 0);
        chk("rst_rise", rise_pulse, 0);
        chk("rst_fall", fall_pulse, 0);
        chk("rst_pending", irq_pending, 0);
        chk("rst_irq", {31'b0, irq}, 0);
        rst = 0;
        tick(2);
        chk("rel_db_early", gpio_db, 0);
        tick(1);
        chk("rel_db", gpio_db, 32'hFFFF_FFFF);
        chk("rel_rise_early", rise_pulse, 0);
        tick(1);
        chk("rel_rise", rise_pulse, 32'hFFFF_FFFF);
        tick(1);
        chk("rel_rise_once", rise_pulse, 0);
        chk("rel_pend_dis", irq_pending, 0);

        pad_in = 0;
        tick(6);
        chk("clear_db", gpio_db, 0);

        deb_limit = 4; pad_in = 32'h1;
        tick(6);
        chk("deb4_db_early", gpio_db, 0);
        tick(1);
        chk("deb4_db", gpio_db, 32'h1);
        tick(1);
        chk("deb4_rise", rise_pulse, 32'h1);
        pad_in = 0;
        tick(10);
        chk("deb4_back", gpio_db, 0);
        pad_in = 32'h1;
        cnt_seen = 0;
        tick(4);
        pad_in = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            cnt_seen += int'(gpio_db[0] | rise_pulse[0]);
        end
        chk("glitch_reject", cnt_seen, 0);

        deb_limit = 3; cnt_seen = 0;
        pad_in = 32'h20;
        for (int i = 0; i < 2; i++) begin tick(1); cnt_seen += int'(rise_pulse[5]); end
        pad_in = 0;
        for (int i = 0; i < 2; i++) begin tick(1); cnt_seen += int'(rise_pulse[5]); end
        pad_in = 32'h20;
        for (int i = 0; i < 5; i++) begin tick(1); cnt_seen += int'(rise_pulse[5]); end
        chk("bounce_db_early", gpio_db, 0);
        tick(1);
        chk("bounce_db", gpio_db, 32'h20);
        for (int i = 0; i < 10; i++) begin tick(1); cnt_seen += int'(rise_pulse[5]); end
        chk("bounce_one_rise", cnt_seen, 1);
        pad_in = 0;
        tick(10);

        deb_limit = 0; rise_en = 32'h4; fall_en = 0;
        pad_in = 32'h4;
        tick(4);
        chk("pend_rise_pulse", rise_pulse, 32'h4);
        chk("pend_not_yet", irq_pending, 0);
        tick(1);
        chk("pend_set", irq_pending, 32'h4);
        chk("pend_irq", {31'b0, irq}, 1);
        pad_in = 0;
        tick(6);
        chk("pend_fall_ignored", irq_pending, 32'h4);
        pad_in = 32'h4;
        tick(4);
        chk("pend_rise2", rise_pulse, 32'h4);
        irq_clr = 32'h4;
        tick(1);
        irq_clr = 0;
        chk("pend_set_wins", irq_pending, 32'h4);
        irq_clr = 32'h4;
        tick(1);
        irq_clr = 0;
        chk("pend_cleared", irq_pending, 0);
        chk("pend_irq_low", {31'b0, irq}, 0);
        pad_in = 0;
        tick(6);
        fall_en = 32'h4;
        tick(3);
        chk("pend_no_retro", irq_pending, 0);
        fall_en = 0; rise_en = 0;

        deb_limit = 100; pad_in = 32'h80;
        tick(52);
        chk("thr_db_early", gpio_db, 0);
        deb_limit = 10;
        tick(1);
        chk("thr_db", gpio_db, 32'h80);

`ifdef GPIO_COND_INVERT_EN
        pad_in = 0; deb_limit = 0;
        tick(6);
        pad_inv = 32'h1;
        tick(2);
        chk("inv_db_early", gpio_db, 0);
        tick(1);
        chk("inv_db", gpio_db, 32'h1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
